// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one outstanding request, programmable wait states,
// little-endian byte/half/word access with alignment and range checking.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_write,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic        o_busy,
    output logic        o_ready,
    output logic        o_error,
    output logic [31:0] o_rdata
);

    localparam int         DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    logic [31:0] r_mem [DEPTH];

    state_t      r_state;
    logic [3:0]  r_count;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_signed;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic [ADDR_WIDTH-1:0] w_inIdx;
    logic                  w_latErr;
    logic                  w_inErr;
    logic                  w_storeNow;
    logic [31:0]           w_mask;
    logic [31:0]           w_laneData;
    logic [31:0]           w_mergedWord;
    logic [31:0]           w_inWord;
    logic [31:0]           w_inLoad;
    logic [31:0]           w_latLoad;

    function automatic logic accessError(input logic [31:0] addr, input logic [1:0] size);
        logic outOfRange;
        logic misaligned;
        outOfRange = (addr >> (ADDR_WIDTH + 2)) != 32'd0;
        misaligned = ((size == 2'b01) && addr[0]) ||
                     ((size == 2'b10) && (addr[1:0] != 2'b00));
        return outOfRange || misaligned || (size == 2'b11);
    endfunction

    function automatic logic [31:0] laneMask(input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] mask;
        case (size)
            2'b00:   mask = 32'h0000_00FF << {lane, 3'b000};
            2'b01:   mask = 32'h0000_FFFF << {lane[1], 4'b0000};
            default: mask = 32'hFFFF_FFFF;
        endcase
        return mask;
    endfunction

    // Replicating the right-aligned store data lets the lane mask alone pick the target bytes.
    function automatic logic [31:0] laneData(input logic [31:0] wdata, input logic [1:0] size);
        logic [31:0] data;
        case (size)
            2'b00:   data = {4{wdata[7:0]}};
            2'b01:   data = {2{wdata[15:0]}};
            default: data = wdata;
        endcase
        return data;
    endfunction

    function automatic logic [31:0] loadExtract(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   result = {{24{sgn & b[7]}}, b};
            2'b01:   result = {{16{sgn & h[15]}}, h};
            default: result = word;
        endcase
        return result;
    endfunction

    assign w_idx        = r_addr[ADDR_WIDTH+1:2];
    assign w_inIdx      = i_addr[ADDR_WIDTH+1:2];
    assign w_latErr     = accessError(r_addr, r_size);
    assign w_inErr      = accessError(i_addr, i_size);
    assign w_storeNow   = (r_state == S_RESP) && r_write && !w_latErr;
    assign w_mask       = laneMask(r_addr[1:0], r_size);
    assign w_laneData   = laneData(r_wdata, r_size);
    assign w_mergedWord = (r_mem[w_idx] & ~w_mask) | (w_laneData & w_mask);

    // A zero-wait load accepted in RESP reads on the same edge the held store commits, so forward it.
    assign w_inWord  = (w_storeNow && (w_inIdx == w_idx)) ? w_mergedWord : r_mem[w_inIdx];
    assign w_inLoad  = (i_write || w_inErr) ? 32'd0
                     : loadExtract(w_inWord, i_addr[1:0], i_size, i_signed);
    assign w_latLoad = (r_write || w_latErr) ? 32'd0
                     : loadExtract(r_mem[w_idx], r_addr[1:0], r_size, r_signed);

    always_ff @(posedge i_clk) begin
        if (!i_reset && w_storeNow) begin
            r_mem[w_idx] <= w_mergedWord;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            o_busy   <= 1'b0;
            o_ready  <= 1'b0;
            o_error  <= 1'b0;
            o_rdata  <= '0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
        end else begin
            o_ready <= 1'b0;
            o_error <= 1'b0;
            o_rdata <= '0;
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (i_req) begin
                        r_write  <= i_write;
                        r_addr   <= i_addr;
                        r_wdata  <= i_wdata;
                        r_size   <= i_size;
                        r_signed <= i_signed;
                        if (WAIT_STATES == 0) begin
                            r_state <= S_RESP;
                            o_busy  <= 1'b0;
                            o_ready <= 1'b1;
                            o_error <= w_inErr;
                            o_rdata <= w_inLoad;
                        end else begin
                            r_state <= S_WAIT;
                            r_count <= WS;
                            o_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (r_count <= 4'd1) begin
                        r_state <= S_RESP;
                        r_count <= '0;
                        o_busy  <= 1'b0;
                        o_ready <= 1'b1;
                        o_error <= w_latErr;
                        o_rdata <= w_latLoad;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 1, 0 and 3 wait states,
// expected responses queued at issue time and compared when Ready arrives.
module tb_dmem_responder;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst, req, wr, sgn, busy, ready, err;
    logic [2:0][31:0] addr, wdata, rdata;
    logic [2:0][1:0]  size;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_dut0 (
        .i_clk(clk), .i_reset(rst[0]), .i_req(req[0]), .i_write(wr[0]), .i_addr(addr[0]),
        .i_wdata(wdata[0]), .i_size(size[0]), .i_signed(sgn[0]), .o_busy(busy[0]),
        .o_ready(ready[0]), .o_error(err[0]), .o_rdata(rdata[0]));
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut1 (
        .i_clk(clk), .i_reset(rst[1]), .i_req(req[1]), .i_write(wr[1]), .i_addr(addr[1]),
        .i_wdata(wdata[1]), .i_size(size[1]), .i_signed(sgn[1]), .o_busy(busy[1]),
        .o_ready(ready[1]), .o_error(err[1]), .o_rdata(rdata[1]));
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_dut2 (
        .i_clk(clk), .i_reset(rst[2]), .i_req(req[2]), .i_write(wr[2]), .i_addr(addr[2]),
        .i_wdata(wdata[2]), .i_size(size[2]), .i_signed(sgn[2]), .o_busy(busy[2]),
        .o_ready(ready[2]), .o_error(err[2]), .o_rdata(rdata[2]));

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        bit          sgn;
        bit          expErr;
        logic [31:0] expData;
    } op_t;

    typedef struct {
        string       tag;
        bit          isLoad;
        bit          err;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic op_t mk(input bit w, input logic [31:0] a, input logic [31:0] wd,
                               input logic [1:0] sz, input bit sg, input bit ee,
                               input logic [31:0] ed);
        op_t o;
        o.wr = w; o.addr = a; o.wdata = wd; o.size = sz; o.sgn = sg;
        o.expErr = ee; o.expData = ed;
        return o;
    endfunction

    function automatic int waitsOf(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("[TB] check %s wrong", tag);
        end
    endtask

    task automatic driveOp(input int d, input op_t o);
        wr[d]    = o.wr;
        addr[d]  = o.addr;
        wdata[d] = o.wdata;
        size[d]  = o.size;
        sgn[d]   = o.sgn;
    endtask

    task automatic pushExpect(input string tag, input op_t o);
        exp_t e;
        e.tag    = tag;
        e.isLoad = !o.wr;
        e.err    = o.expErr;
        e.data   = o.expErr ? 32'd0 : o.expData;
        sb.push_back(e);
    endtask

    task automatic popCompare(input int d);
        exp_t e;
        if (sb.size() == 0) begin
            checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        checkOutput({e.tag, "_err"}, {31'd0, err[d]}, {31'd0, e.err});
        if (e.isLoad) checkOutput({e.tag, "_rdata"}, rdata[d], e.data);
    endtask

    // Issue one request to an idle instance (called #1 after an edge) and wait for its response.
    task automatic applyStimulus(input int d, input op_t o, input string tag);
        int cyc;
        driveOp(d, o);
        pushExpect(tag, o);
        req[d] = 1'b1;
        @(posedge clk); #1;
        req[d] = 1'b0;
        cyc = 1;
        checkOutput({tag, "_busy"}, {31'd0, busy[d]}, {31'd0, waitsOf(d) > 0});
        while (!ready[d] && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput({tag, "_lat"}, 32'(cyc), 32'(waitsOf(d) + 1));
        if (ready[d]) popCompare(d);
        else void'(sb.pop_front());
        @(posedge clk); #1;
        checkOutput({tag, "_pulse"}, {31'd0, ready[d]}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        op_t seq0[$];
        op_t burst[$];
        op_t o;
        int  cnt;

        rst = 3'b111; req = '0; wr = '0; sgn = '0; addr = '0; wdata = '0; size = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("rst%0d_busy", d),  {31'd0, busy[d]},  32'd0);
            checkOutput($sformatf("rst%0d_ready", d), {31'd0, ready[d]}, 32'd0);
            checkOutput($sformatf("rst%0d_err", d),   {31'd0, err[d]},   32'd0);
            checkOutput($sformatf("rst%0d_rdata", d), rdata[d],          32'd0);
        end
        rst = 3'b000;

        // One wait state: stores, sign/zero-extended loads, error cases, lane isolation.
        seq0.push_back(mk(1, 32'h10,   32'hDEADBEEF, SZ_W, 0, 0, 32'h0));
        seq0.push_back(mk(0, 32'h10,   32'h0,        SZ_W, 0, 0, 32'hDEADBEEF));
        seq0.push_back(mk(1, 32'h13,   32'hAAAAAA80, SZ_B, 0, 0, 32'h0));
        seq0.push_back(mk(0, 32'h13,   32'h0,        SZ_B, 1, 0, 32'hFFFFFF80));
        seq0.push_back(mk(0, 32'h13,   32'h0,        SZ_B, 0, 0, 32'h00000080));
        seq0.push_back(mk(0, 32'h10,   32'h0,        SZ_W, 0, 0, 32'h80ADBEEF));
        seq0.push_back(mk(0, 32'h12,   32'h0,        SZ_H, 1, 0, 32'hFFFF80AD));
        seq0.push_back(mk(0, 32'h10,   32'h0,        SZ_B, 0, 0, 32'h000000EF));
        seq0.push_back(mk(0, 32'h10,   32'h0,        SZ_H, 0, 0, 32'h0000BEEF));
        seq0.push_back(mk(0, 32'h10,   32'h0,        SZ_H, 1, 0, 32'hFFFFBEEF));
        seq0.push_back(mk(0, 32'h11,   32'h0,        SZ_H, 0, 1, 32'h0));
        seq0.push_back(mk(0, 32'h12,   32'h0,        SZ_W, 0, 1, 32'h0));
        seq0.push_back(mk(0, 32'h10,   32'h0,        SZ_X, 0, 1, 32'h0));
        seq0.push_back(mk(1, 32'h11,   32'h00001234, SZ_H, 0, 1, 32'h0));
        seq0.push_back(mk(1, 32'h1010, 32'h00000000, SZ_W, 0, 1, 32'h0));
        seq0.push_back(mk(1, 32'h10,   32'h00000000, SZ_X, 0, 1, 32'h0));
        seq0.push_back(mk(0, 32'h10,   32'h0,        SZ_W, 0, 0, 32'h80ADBEEF));
        seq0.push_back(mk(0, 32'h1000, 32'h0,        SZ_W, 0, 1, 32'h0));
        seq0.push_back(mk(1, 32'h12,   32'hFFFFCAFE, SZ_H, 0, 0, 32'h0));
        seq0.push_back(mk(0, 32'h10,   32'h0,        SZ_W, 0, 0, 32'hCAFEBEEF));
        seq0.push_back(mk(1, 32'hFFC,  32'h01020304, SZ_W, 0, 0, 32'h0));
        seq0.push_back(mk(0, 32'hFFC,  32'h0,        SZ_W, 0, 0, 32'h01020304));
        foreach (seq0[i]) applyStimulus(0, seq0[i], $sformatf("d0_op%0d", i));

        // Zero wait states: Req held high, one response per cycle, store-then-load forwarding.
        burst.push_back(mk(1, 32'h00, 32'hA1A2A3A4, SZ_W, 0, 0, 32'h0));
        burst.push_back(mk(1, 32'h04, 32'hB1B2B3B4, SZ_W, 0, 0, 32'h0));
        burst.push_back(mk(0, 32'h00, 32'h0,        SZ_W, 0, 0, 32'hA1A2A3A4));
        burst.push_back(mk(0, 32'h04, 32'h0,        SZ_W, 0, 0, 32'hB1B2B3B4));
        burst.push_back(mk(1, 32'h20, 32'h11223344, SZ_W, 0, 0, 32'h0));
        burst.push_back(mk(0, 32'h20, 32'h0,        SZ_W, 0, 0, 32'h11223344));
        burst.push_back(mk(0, 32'h06, 32'h0,        SZ_H, 1, 0, 32'hFFFFB1B2));
        burst.push_back(mk(0, 32'h01, 32'h0,        SZ_B, 0, 0, 32'h000000A3));
        burst.push_back(mk(1, 32'h21, 32'h00000099, SZ_B, 0, 0, 32'h0));
        burst.push_back(mk(0, 32'h20, 32'h0,        SZ_W, 0, 0, 32'h11229944));
        driveOp(1, burst[0]);
        pushExpect("d1_b0", burst[0]);
        req[1] = 1'b1;
        for (int i = 0; i < burst.size(); i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("d1_b%0d_ready", i), {31'd0, ready[1]}, 32'd1);
            checkOutput($sformatf("d1_b%0d_busy", i),  {31'd0, busy[1]},  32'd0);
            if (ready[1]) popCompare(1);
            else void'(sb.pop_front());
            if (i + 1 < burst.size()) begin
                driveOp(1, burst[i+1]);
                pushExpect($sformatf("d1_b%0d", i + 1), burst[i+1]);
            end else begin
                req[1] = 1'b0;
            end
        end
        @(posedge clk); #1;
        checkOutput("d1_burst_end_ready", {31'd0, ready[1]}, 32'd0);

        // Req together with Reset is discarded.
        driveOp(1, mk(1, 32'h00, 32'hDEAD0000, SZ_W, 0, 0, 32'h0));
        req[1] = 1'b1;
        rst[1] = 1'b1;
        @(posedge clk); #1;
        req[1] = 1'b0;
        rst[1] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (ready[1]) cnt++;
            @(posedge clk); #1;
        end
        checkOutput("d1_rstreq_readies", 32'(cnt), 32'd0);
        applyStimulus(1, mk(0, 32'h00, 32'h0, SZ_W, 0, 0, 32'hA1A2A3A4), "d1_rstreq_mem");

        // Three wait states: Req toggled while busy is ignored.
        applyStimulus(2, mk(1, 32'h40, 32'h55AA55AA, SZ_W, 0, 0, 32'h0), "d2_st");
        o = mk(0, 32'h40, 32'h0, SZ_W, 0, 0, 32'h55AA55AA);
        driveOp(2, o);
        pushExpect("d2_tog", o);
        req[2] = 1'b1;
        @(posedge clk); #1;
        driveOp(2, mk(1, 32'h40, 32'h00000000, SZ_W, 0, 0, 32'h0));
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (ready[2]) begin
                cnt++;
                popCompare(2);
            end
            req[2] = (k == 0 || k == 2);
            @(posedge clk); #1;
        end
        checkOutput("d2_tog_readies", 32'(cnt), 32'd1);
        applyStimulus(2, mk(0, 32'h40, 32'h0, SZ_W, 0, 0, 32'h55AA55AA), "d2_after_tog");

        // Reset in the middle of a store's wait: no response, word untouched.
        driveOp(2, mk(1, 32'h40, 32'h12345678, SZ_W, 0, 0, 32'h0));
        req[2] = 1'b1;
        @(posedge clk); #1;
        req[2] = 1'b0;
        checkOutput("d2_abort_busy_pre", {31'd0, busy[2]}, 32'd1);
        @(posedge clk); #1;
        rst[2] = 1'b1;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        checkOutput("d2_abort_busy", {31'd0, busy[2]}, 32'd0);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (ready[2]) cnt++;
            @(posedge clk); #1;
        end
        checkOutput("d2_abort_readies", 32'(cnt), 32'd0);
        applyStimulus(2, mk(0, 32'h40, 32'h0, SZ_W, 0, 0, 32'h55AA55AA), "d2_abort_mem");

        checkOutput("sb_leftover", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, gives the word-address width; the array holds 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter WAIT_STATES, default 1, gives the number of extra wait cycles, in the range 0..15, inserted before a response.
REQ-003 Clock  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 Reset  input  1  synchronous reset, active-high, sampled on the rising edge of Clock.
REQ-005 Req  input  1  request strobe from the MEM stage; it is sampled only when Busy=0.
REQ-006 Write  input  1  1=store, 0=load; sampled with Req.
REQ-007 Addr  input  32  byte address; sampled with Req.
REQ-008 WData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]); sampled with Req.
REQ-009 Size  input  2  access size: 00=byte, 01=half, 10=word, 11=illegal.
REQ-010 Signed  input  1  for loads, 1 selects sign-extension and 0 selects zero-extension.
REQ-011 Busy  output  1  high while a request is held and its response is not yet due.
REQ-012 Ready  output  1  one-cycle pulse that completes the held request.
REQ-013 Error  output  1  valid only while Ready=1; flags a misaligned, out-of-range or illegal-size access.
REQ-014 RData  output  32  load result, valid while Ready=1 with Write=0 and Error=0.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 IDLE and RESP SHALL drive Busy=0; WAIT SHALL drive Busy=1.
REQ-017 Req=1 with Busy=0 SHALL latch Write, Addr, WData, Size and Signed on that edge.
REQ-018 After accepting a request, the FSM SHALL go to WAIT with a counter loaded to WAIT_STATES, or go directly to RESP if WAIT_STATES=0.
REQ-019 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL enter RESP on the edge where the counter is 1.
REQ-020 Latency: Req accepted at edge n SHALL produce Ready=1 during cycle n+1+WAIT_STATES.
REQ-021 Ready SHALL be high only in RESP, for exactly one cycle per accepted request.
REQ-022 Req=1 in RESP SHALL accept a new request (back-to-back); otherwise RESP SHALL return to IDLE.
REQ-023 Req while Busy=1 SHALL be ignored, with no latch and no queueing.
REQ-024 Word index SHALL be Addr[ADDR_WIDTH+1:2].
REQ-025 Any 1 in Addr[31:ADDR_WIDTH+2] SHALL be an out-of-range access.
REQ-026 A half access with Addr[0]=1 SHALL be misaligned.
REQ-027 A word access with Addr[1:0] not equal to 00 SHALL be misaligned.
REQ-028 An out-of-range, misaligned or Size=11 access SHALL give Error=1 with Ready, no array write, and RData=0.
REQ-029 Byte lanes SHALL be little-endian: lane k is bits [8k+7:8k], and it is selected by Addr[1:0]=k.
REQ-030 A store SHALL update the array on the RESP edge, touching only the addressed lanes (1, 2 or 4 bytes); all other lanes keep their value.
REQ-031 A load SHALL read the array on the edge entering RESP; RData is registered and held at 0 outside RESP.
REQ-032 A byte load SHALL return lane Addr[1:0] in [7:0], extended per Signed.
REQ-033 A half load SHALL return lanes {Addr[1],1} and {Addr[1],0} in [15:0], extended per Signed.
REQ-034 A word load SHALL return all 32 bits unmodified.
REQ-035 A load following a store to the same address SHALL return the stored data, with no stale read-after-write.
REQ-036 When Req and Reset are both 1, Reset SHALL win and the request SHALL be discarded.

Reset
REQ-037 Reset=1 SHALL force the IDLE state, counter=0, Busy=0, Ready=0, Error=0, RData=0, and clear all latched request fields.
REQ-038 Reset during WAIT or RESP SHALL abort the request, with no array write and no Ready pulse.
REQ-039 Array contents SHALL NOT be cleared by Reset.

Verification
REQ-040 WAIT_STATES=1: word store 0xDEADBEEF to 0x10, then word load from 0x10 -> each Ready arrives 2 cycles after acceptance, Error=0, RData=0xDEADBEEF.
REQ-041 Byte store 0x80 to 0x13, then loads from 0x13 -> Signed=1 gives RData=0xFFFFFF80; Signed=0 gives 0x00000080; word load from 0x10 gives 0x80ADBEEF.
REQ-042 Half load from 0x11, word load from 0x12, and Size=11 -> each gives Ready with Error=1, RData=0, and array unchanged; Addr=0x00001000 with ADDR_WIDTH=10 -> Error=1.
REQ-043 WAIT_STATES=0 with Req held high for 4 loads -> Ready high on 4 consecutive cycles, Busy=0 throughout.
REQ-044 WAIT_STATES=3: Req toggled during WAIT -> ignored, exactly one Ready; Reset during WAIT of a store -> no Ready, target word unchanged.
